// File: rtl/array_ops_pkg.sv
`default_nettype none
// ============================================================================
// Module      : array_ops_pkg
// Description : Packer state encoding and the (row, col) to sub-array flat
//               slice index mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package array_ops_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } pack_state_e;

  // The leading sub-array holds rows [0,sub_rows) column-major; the rest follow it.
  function automatic int sub_array_flat_index(input int r, input int c,
                                              input int rows, input int cols,
                                              input int sub_rows);
    if (r < sub_rows)
      return c * sub_rows + r;
    else
      return cols * sub_rows + c * (rows - sub_rows) + (r - sub_rows);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sub_array_stream_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : sub_array_stream_packer_if
// Description : Element input stream and flat frame output stream of the packer.
// Revision    : 1.0 - initial release
// ============================================================================
interface sub_array_stream_packer_if #(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS      = 8,
  parameter int COLS      = 8
);
  logic [BIT_WIDTH-1:0]           in_data;
  logic                           in_valid;
  logic                           in_last;
  logic                           in_ready;
  logic [ROWS*COLS*BIT_WIDTH-1:0] out_flat;
  logic                           out_valid;
  logic                           out_ready;
  logic                           err_frame;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_flat, out_valid, err_frame
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_flat, out_valid, err_frame
  );
endinterface
`default_nettype wire

// File: rtl/sub_array_index_calc.sv
`default_nettype none
// ============================================================================
// Module      : sub_array_index_calc
// Description : Combinational (row, col) to flat slice index in sub-array order.
// Revision    : 1.0 - initial release
// ============================================================================
module sub_array_index_calc
  import array_ops_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int SUB_ROWS = 4,
  parameter int RW       = 3,
  parameter int CW       = 3,
  parameter int PW       = 6
) (
  input  logic [RW-1:0] i_row,
  input  logic [CW-1:0] i_col,
  output logic [PW-1:0] o_p
);

  assign o_p = PW'(sub_array_flat_index(int'(i_row), int'(i_col), ROWS, COLS, SUB_ROWS));

endmodule
`default_nettype wire

// File: rtl/sub_array_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : sub_array_stream_packer
// Description : Packs a row-major element stream into one flat frame laid out
//               as a leading sub-array followed by the remaining rows.
// Revision    : 1.0 - initial release
// ============================================================================
module sub_array_stream_packer
  import array_ops_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int SUB_ROWS  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  sub_array_stream_packer_if.slave  bus
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
  localparam logic [RW-1:0] c_row_max = RW'(ROWS - 1);
  localparam logic [CW-1:0] c_col_max = CW'(COLS - 1);

  generate
    if (SUB_ROWS < 0 || SUB_ROWS > ROWS) begin : g_bad_sub_rows
      $error("SUB_ROWS must lie in 0..ROWS");
    end
  endgenerate

  pack_state_e                    r_state;
  pack_state_e                    w_state_next;
  logic [RW-1:0]                  r_row;
  logic [CW-1:0]                  r_col;
  logic [PW-1:0]                  w_p;
  logic [ROWS*COLS*BIT_WIDTH-1:0] r_flat;
  logic                           r_err;
  logic                           w_beat;
  logic                           w_last_pos;
  logic                           w_early_last;

  sub_array_index_calc #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .SUB_ROWS (SUB_ROWS),
    .RW       (RW),
    .CW       (CW),
    .PW       (PW)
  ) u_index_calc (
    .i_row (r_row),
    .i_col (r_col),
    .o_p   (w_p)
  );

  assign bus.in_ready  = (r_state == FILL) & ~rst;
  assign bus.out_valid = (r_state == FULL);
  assign bus.out_flat  = r_flat;
  assign bus.err_frame = r_err;

  assign w_beat       = bus.in_valid & bus.in_ready;
  assign w_last_pos   = (r_row == c_row_max) && (r_col == c_col_max);
  assign w_early_last = w_beat & bus.in_last & ~w_last_pos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FILL:    if (w_beat && w_last_pos) w_state_next = FULL;
      FULL:    if (bus.out_ready)        w_state_next = FILL;
      default: w_state_next = FILL;
    endcase
  end

  // An early in_last drops its element and restarts the frame from (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row  <= '0;
      r_col  <= '0;
      r_flat <= '0;
      r_err  <= 1'b0;
    end else if (w_early_last) begin
      r_row <= '0;
      r_col <= '0;
      r_err <= 1'b1;
    end else if (w_beat) begin
      for (int i = 0; i < ROWS * COLS; i++) begin
        if (w_p == PW'(i)) r_flat[i*BIT_WIDTH +: BIT_WIDTH] <= bus.in_data;
      end
      if (w_last_pos) begin
        r_row <= '0;
        r_col <= '0;
        if (!bus.in_last) r_err <= 1'b1;
      end else if (r_col == c_col_max) begin
        r_col <= '0;
        r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire
